// File: rtl/pwm_sched_pkg.sv
// Shared types and default sizes for the PWM duty scheduler.
package pwm_sched_pkg;

   localparam int unsigned NUM_REQ_DEF = 4;
   localparam int unsigned W_DEF       = 16;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// after the pointer, wrapping modulo NUM_REQ. No grant when disabled.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IW-1:0]      ptr_i,
   input  logic               en_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IW-1:0]      grant_idx_o
);

   logic          found;
   logic [IW-1:0] idx;

   // Scan from the pointer upwards and take the first valid requester.
   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      idx         = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         idx = IW'((int'(ptr_i) + i) % int'(NUM_REQ));
         if (en_i && !found && req_i[idx]) begin
            grant_o[idx] = 1'b1;
            grant_idx_o  = idx;
            found        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pwm_duty_scheduler.sv
// PWM generator whose duty cycle is shared by several requesters. Updates are
// accepted one at a time into a shadow slot and committed only at period
// boundaries, so every emitted period uses a single duty value.
//
// state | meaning
// IDLE  | not running (en low or period zero); cnt and pwm held at 0
// RUN   | counting through periods and emitting the waveform
module pwm_duty_scheduler
   import pwm_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ = NUM_REQ_DEF,
   parameter int unsigned W       = W_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en_i,
   input  logic [W-1:0]               period_i,
   input  logic [NUM_REQ-1:0]         req_valid_i,
   input  logic [NUM_REQ-1:0][W-1:0]  req_duty_i,
   output logic [NUM_REQ-1:0]         req_ready_o,
   output logic [W-1:0]               active_duty_o,
   output logic                       pending_o,
   output logic                       period_start_o,
   output logic                       pwm_out_o
);

   localparam int unsigned IW = $clog2(NUM_REQ);

   state_e        state_q;
   logic [W-1:0]  cnt_q;
   logic [W-1:0]  active_q;
   logic [W-1:0]  shadow_q;
   logic          pending_q;
   logic [IW-1:0] ptr_q;
   logic          pstart_q;
   logic          pwm_q;

   logic [NUM_REQ-1:0] grant;
   logic [IW-1:0]      grant_idx;
   logic [IW-1:0]      ptr_d;
   logic [W-1:0]       shadow_d;
   logic [W-1:0]       sel_duty;
   logic [W-1:0]       duty_commit;
   logic [W-1:0]       cnt_inc;
   logic               accept;
   logic               run;
   logic               start_period;

   // Arbitration is only enabled while the shadow slot is free.
   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_arb (
      .req_i       (req_valid_i),
      .ptr_i       (ptr_q),
      .en_i        (!pending_q),
      .grant_o     (grant),
      .grant_idx_o (grant_idx)
   );

   // Accept decode, clamp against the live period, and boundary detection.
   always_comb begin
      accept       = |(req_valid_i & grant);
      sel_duty     = req_duty_i[grant_idx];
      shadow_d     = (sel_duty > period_i) ? period_i : sel_duty;
      ptr_d        = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
      run          = en_i && (period_i != '0);
      // >= rather than == so a period shrunk below cnt still ends cleanly.
      start_period = run && ((state_q == IDLE) || (cnt_q >= period_i - W'(1)));
      duty_commit  = pending_q ? shadow_q : active_q;
      cnt_inc      = cnt_q + W'(1);
   end

   // Shadow data and round-robin pointer capture on each transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
         ptr_q    <= '0;
      end else if (accept) begin
         shadow_q <= shadow_d;
         ptr_q    <= ptr_d;
      end
   end

   // Run/idle FSM with period counter, commit and registered outputs.
   // Accept and commit never coincide (accept needs an empty shadow), so on
   // a commit edge pending simply takes the accept flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         active_q  <= '0;
         pending_q <= 1'b0;
         pstart_q  <= 1'b0;
         pwm_q     <= 1'b0;
      end else if (!run) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         active_q  <= duty_commit;
         pending_q <= accept;
         pstart_q  <= 1'b0;
         pwm_q     <= 1'b0;
      end else if (start_period) begin
         state_q   <= RUN;
         cnt_q     <= '0;
         active_q  <= duty_commit;
         pending_q <= accept;
         pstart_q  <= 1'b1;
         pwm_q     <= (duty_commit != '0);
      end else begin
         state_q   <= RUN;
         cnt_q     <= cnt_inc;
         pending_q <= pending_q | accept;
         pstart_q  <= 1'b0;
         pwm_q     <= (cnt_inc < active_q);
      end
   end

   assign req_ready_o    = grant;
   assign active_duty_o  = active_q;
   assign pending_o      = pending_q;
   assign period_start_o = pstart_q;
   assign pwm_out_o      = pwm_q;

endmodule
